// File: rtl/divider_4bit_reconstructor.sv
// ---------------------------------------------------------------------------
// divider_4bit_reconstructor
//
// Purpose:
//   Rebuilds a dividend from a divider's quotient/divisor/remainder triple,
//   dividend = quotient * divisor + remainder. A shift-and-add multiplier
//   handles one quotient bit per clock, LSB first. The block also flags
//   triples that no correct divider could produce (remainder >= divisor with
//   a non-zero divisor). A zero divisor follows the divider's convention:
//   the result is just the remainder.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   request, sampled only while idle
//   quotient   in   WIDTH-bit quotient operand
//   divisor    in   WIDTH-bit divisor operand
//   remainder  in   WIDTH-bit remainder operand
//   busy       out  high while an operation is in progress
//   done       out  one-cycle pulse, dividend/rem_err just updated
//   dividend   out  2*WIDTH-bit reconstructed dividend, held between ops
//   rem_err    out  remainder inconsistent with divisor, updated with dividend
// ---------------------------------------------------------------------------
module divider_4bit_reconstructor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dividend,
    output logic                 rem_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    logic [WIDTH-1:0]     r_q;          // quotient, shifted right each step
    logic [2*WIDTH-1:0]   r_d;          // divisor << k, shifted left each step
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_err_pend;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_dividend;
    logic                 r_rem_err;

    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_sum;

    // Partial product for the current quotient bit. The sum cannot overflow
    // 2*WIDTH bits: (2^W-1)^2 + (2^W-1) < 2^(2W).
    assign w_addend  = r_q[0] ? r_d : '0;
    assign w_acc_sum = r_acc + w_addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= '0;
            r_d        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dividend <= '0;
            r_rem_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // Operands are captured here; later input changes are ignored.
                r_q        <= quotient;
                r_d        <= {{WIDTH{1'b0}}, divisor};
                r_acc      <= {{WIDTH{1'b0}}, remainder};
                r_cnt      <= '0;
                r_err_pend <= (divisor != '0) && (remainder >= divisor);
                r_busy     <= 1'b1;
            end else if (r_state == S_MUL) begin
                r_acc <= w_acc_sum;
                r_q   <= r_q >> 1;
                r_d   <= r_d << 1;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    // Publish the final sum directly; r_acc is not yet updated.
                    r_dividend <= w_acc_sum;
                    r_rem_err  <= r_err_pend;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign dividend = r_dividend;
    assign rem_err  = r_rem_err;

endmodule

// File: doc/divider_4bit_reconstructor.md
Name: divider_4bit_reconstructor

Overview:
- Sequential inverse of the 4-bit divider: rebuilds the dividend from a quotient/divisor/remainder triple as dividend = quotient*divisor + remainder.
- Uses a shift-and-add multiplier, one quotient bit per clock.
- Sits on the verification/self-check path: divider outputs feed this block and the rebuilt value is compared against the original dividend.
- Also flags triples that no correct divider could produce.

Parameters:
- WIDTH, 4, operand width in bits; the result is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while idle
- quotient  input  WIDTH  quotient operand
- divisor  input  WIDTH  divisor operand
- remainder  input  WIDTH  remainder operand
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result valid and updated
- dividend  output  2*WIDTH  reconstructed dividend; held between operations
- rem_err  output  1  remainder inconsistent with divisor; updated with dividend

Behaviour:
- Reset (rst high at a rising edge):
  - state <= IDLE; busy=0, done=0, dividend=0, rem_err=0.
  - Internal accumulator, shift registers and counter are cleared.
  - Reset has priority over all other inputs.
- States:
  - IDLE: busy=0, waiting for start.
  - MUL: busy=1, iterating.
  - No separate DONE state; done is a registered pulse.
- Acceptance (edge E0): start=1 sampled in IDLE.
  - Capture quotient and divisor.
  - acc <= zero-extended remainder; counter <= 0.
  - err_pend <= (divisor != 0) && (remainder >= divisor).
  - state <= MUL, busy <= 1.
- Iteration: edges E1..E_WIDTH, one per quotient bit, LSB first.
  - If quotient bit k is 1: acc += divisor << k.
  - All arithmetic is 2*WIDTH bits wide; no overflow is possible, since the max is (2^W-1)^2 + (2^W-1) < 2^(2W).
- Completion (edge E_WIDTH):
  - dividend <= final acc; rem_err <= err_pend.
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: done is visible WIDTH cycles after the acceptance edge (4 for the default). Latency is fixed and independent of the operand values.
- Throughput: start may be high in the cycle done is high and is accepted at that edge. Back-to-back period is WIDTH+1 cycles.
- start while busy=1: ignored, no queuing. Operand changes while busy have no effect, because the values were captured at E0.
- dividend and rem_err change only at completion edges or reset; they hold their value otherwise, including across ignored starts.
- Zero divisor follows the divider's convention (quotient=0, remainder=dividend):
  - The result is just the remainder, whatever the quotient is.
  - rem_err=0.
- Reset mid-operation: the operation is aborted with no done pulse. dividend and rem_err return to 0. The block is ready for start on the first edge after rst deasserts.

Test Plan:
- Basic case: rst for 2 cycles, then start with q=3, d=5, r=2 -> busy high for 4 cycles; done pulses exactly once, 4 cycles after acceptance; dividend=17, rem_err=0.
- Maximum legal values: q=15, d=15, r=14 -> dividend=239, rem_err=0. Then q=15, d=15, r=15 -> dividend=240, rem_err=1.
- Zero divisor: d=0, q=7, r=9 -> dividend=9, rem_err=0. Also q=0, d=6, r=5 -> dividend=5.
- Handshake: hold start high continuously with the operands changing every cycle -> exactly one acceptance per 5 cycles; each result matches the operands captured at its acceptance edge; mid-operation operand changes are ignored; dividend is stable between done pulses.
- Reset mid-operation: start (q=9, d=3, r=1), then assert rst at the 2nd iteration edge -> busy=0, no done pulse, dividend=0. A new start (q=2, d=4, r=3) then yields 11.
- Exhaustive round-trip: for all dividend/divisor pairs in 0..15, run the reference divider model and feed its outputs in -> dividend matches the original for every divisor != 0, and rem_err is never set.
